call_stack: RTL
===============

CALL_STACK -- requirements
Module: call_stack

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, return-address width in bits.
REQ-002 Parameter DEPTH, default 16, number of entries; power of two, >= 2.
REQ-003 Derived constant PTR_WIDTH = clog2(DEPTH)+1, width of the occupancy count.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 push  input  1  push request for this cycle.
REQ-007 pop  input  1  pop request for this cycle.
REQ-008 flush  input  1  discard all entries.
REQ-009 clr_err  input  1  clear the error condition and leave ERR.
REQ-010 push_data  input  ADDR_WIDTH  address to push, typically the PC.
REQ-011 top_out  output  ADDR_WIDTH  registered copy of the top entry; 0 when empty.
REQ-012 count  output  PTR_WIDTH  number of valid entries.
REQ-013 empty, full  output  1 each  count==0 / count==DEPTH.
REQ-014 overflow, underflow  output  1 each  sticky error flags.
REQ-015 err  output  1  high while the FSM is in ERR.

Function
REQ-016 The FSM SHALL have two states, RUN and ERR; ERR blocks all push/pop effects.
REQ-017 In RUN, push only with !full SHALL write mem[count]<=push_data, increment count, and set top_out<=push_data, all visible the next cycle.
REQ-018 In RUN, pop only with !empty SHALL decrement count and set top_out<=mem[count-2], or 0 if count becomes 0; popped data is top_out as seen in the pop cycle.
REQ-019 In RUN, push and pop together with !empty SHALL replace the top: mem[count-1]<=push_data, count unchanged, top_out<=push_data.
REQ-020 push and pop together while empty SHALL behave as push only.
REQ-021 push only while full SHALL leave contents and count unchanged, set overflow, and enter ERR.
REQ-022 pop only while empty SHALL leave state unchanged, set underflow, and enter ERR.
REQ-023 Push+pop while full SHALL be a legal replace, with no overflow.
REQ-024 In ERR, push and pop SHALL be ignored; count, contents and top_out are held.
REQ-025 clr_err SHALL clear overflow and underflow and move ERR->RUN next cycle; in RUN it clears any stale flags; push/pop in the same cycle are ignored.
REQ-026 flush SHALL set count<=0 and top_out<=0 next cycle, with priority over push/pop, in either state; it does not alter error flags or state unless clr_err is also high.
REQ-027 Count arithmetic SHALL be PTR_WIDTH unsigned; mem indices use the low clog2(DEPTH) bits; count never exceeds DEPTH or wraps below 0.
REQ-028 empty, full and err SHALL be decoded combinationally from registered count/state only, with no input-to-output combinational path.

Reset
REQ-029 Asserting reset SHALL immediately force: state RUN, count 0, top_out 0, overflow 0, underflow 0, err 0, empty 1, full 0.
REQ-030 Memory contents need not be reset; no stale entry SHALL ever be observable on top_out.
REQ-031 Reset mid-operation SHALL abandon any in-flight push/pop; the first edge after deassertion is processed normally.

Structure
REQ-032 The shared package pampy_pkg SHALL hold the default ADDR_WIDTH, the DEPTH default, and the RUN/ERR state encoding.
REQ-033 Storage SHALL be one sub-module, call_stack_mem: DEPTH x ADDR_WIDTH, one write port, two async read ports (index count-1 and count-2).
REQ-034 The FSM, count, flags and top_out register SHALL live in call_stack.

Verification (DEPTH=4, ADDR_WIDTH=12)
REQ-035 Push 0x100,0x200,0x300,0x400 -> count 4, full=1, top_out=0x400; pop x4 -> top_out 0x300,0x200,0x100,0, then empty=1.
REQ-036 Full stack, push 0x500 -> overflow=1, err=1, count 4, top_out 0x400; further push/pop ignored; clr_err -> err=0, overflow=0, top_out 0x400.
REQ-037 Empty stack, pop -> underflow=1, err=1, count 0; clr_err with pop asserted -> RUN, count still 0.
REQ-038 Stack {0x100,0x200}, push+pop with 0x2AA -> count 2, top_out 0x2AA; pop -> top_out 0x100; full stack push+pop -> no overflow.
REQ-039 Stack of 3, flush+push same cycle -> count 0, top_out 0; async reset asserted mid-push between edges -> outputs at reset values immediately, with no write.

Source files
------------

// File: rtl/pampy_pkg.sv
// Shared defaults and FSM encoding for the return-address call stack.
package pampy_pkg;

  localparam int ADDR_WIDTH_DEF = 12;
  localparam int DEPTH_DEF      = 16;

  typedef enum logic {
    RUN = 1'b0,
    ERR = 1'b1
  } state_t;

endpackage

// File: rtl/call_stack_mem.sv
// Call-stack storage: one synchronous write port, two asynchronous read ports.
module call_stack_mem
  import pampy_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [ADDR_WIDTH-1:0]      wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr_top,
  input  logic [$clog2(DEPTH)-1:0]   raddr_below,
  output logic [ADDR_WIDTH-1:0]      rdata_top,
  output logic [ADDR_WIDTH-1:0]      rdata_below
);

  logic [ADDR_WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately not reset; the top register masks stale data.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_top   = mem[raddr_top];
  assign rdata_below = mem[raddr_below];

endmodule

// File: rtl/call_stack.sv
// Hardware return-address stack with sticky overflow/underflow and a RUN/ERR FSM.
module call_stack
  import pampy_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic                      pop,
  input  logic                      flush,
  input  logic                      clr_err,
  input  logic [ADDR_WIDTH-1:0]     push_data,
  output logic [ADDR_WIDTH-1:0]     top_out,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      empty,
  output logic                      full,
  output logic                      overflow,
  output logic                      underflow,
  output logic                      err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam logic [PTR_W-1:0] FULL_CNT = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] ONE_CNT  = PTR_W'(1);

  state_t                 state, state_nx;
  logic [PTR_W-1:0]       count_nx;
  logic [ADDR_WIDTH-1:0]  top_nx;
  logic                   ovf_nx, unf_nx;
  logic                   we;
  logic [IDX_W-1:0]       waddr;
  logic [IDX_W-1:0]       idx_top, idx_below;
  logic [ADDR_WIDTH-1:0]  rd_top, rd_below;

  assign idx_top   = count[IDX_W-1:0] - IDX_W'(1);
  assign idx_below = count[IDX_W-1:0] - IDX_W'(2);

  call_stack_mem #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk         (clk),
    .we          (we),
    .waddr       (waddr),
    .wdata       (push_data),
    .raddr_top   (idx_top),
    .raddr_below (idx_below),
    .rdata_top   (rd_top),
    .rdata_below (rd_below)
  );

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
  assign err   = (state == ERR);

  always_comb begin
    state_nx = state;
    count_nx = count;
    top_nx   = top_out;
    ovf_nx   = overflow;
    unf_nx   = underflow;
    we       = 1'b0;
    waddr    = count[IDX_W-1:0];

    if (state == RUN && !clr_err && !flush) begin
      // push+pop on an empty stack degenerates to a plain push
      if (push && (!pop || empty)) begin
        if (!full) begin
          we       = 1'b1;
          waddr    = count[IDX_W-1:0];
          count_nx = count + ONE_CNT;
          top_nx   = push_data;
        end else begin
          ovf_nx   = 1'b1;
          state_nx = ERR;
        end
      end else if (push && pop) begin
        we     = 1'b1;
        waddr  = idx_top;
        top_nx = push_data;
      end else if (pop) begin
        if (!empty) begin
          count_nx = count - ONE_CNT;
          top_nx   = (count == ONE_CNT) ? '0 : rd_below;
        end else begin
          unf_nx   = 1'b1;
          state_nx = ERR;
        end
      end
    end

    if (clr_err) begin
      ovf_nx   = 1'b0;
      unf_nx   = 1'b0;
      state_nx = RUN;
      top_nx   = empty ? '0 : rd_top;
    end

    // flush wins over any push/pop and never touches the error state
    if (flush) begin
      count_nx = '0;
      top_nx   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      count     <= '0;
      top_out   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state     <= state_nx;
      count     <= count_nx;
      top_out   <= top_nx;
      overflow  <= ovf_nx;
      underflow <= unf_nx;
    end
  end

endmodule
